// File: rtl/axis_rgb_unpacker_pkg.sv
// axis_rgb_unpacker_pkg: pixel byte lanes, gearbox phase encoding, default frame geometry and a pixel packing helper
package axis_rgb_unpacker_pkg;
  localparam int R_LSB = 0;
  localparam int G_LSB = 8;
  localparam int B_LSB = 16;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;
  function automatic logic [31:0] pack_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pack_px = '0;
    pack_px[R_LSB+:8] = r;
    pack_px[G_LSB+:8] = g;
    pack_px[B_LSB+:8] = b;
  endfunction
endpackage

// File: rtl/axis_rgb_unpacker_reg_slice.sv
// axis_reg_slice: single-stage valid/ready output register (clk, rst_n, s_data/s_valid/s_ready in, m_data/m_valid/m_ready out)
module axis_reg_slice #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);
  assign s_ready = !m_valid | m_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) m_data <= s_data;
    end
  end
endmodule

// File: rtl/axis_rgb_unpacker.sv
// axis_rgb_unpacker: 24bpp packed AXIS (s_t*) to 1 pixel/beat AXIS (m_t*, m_tuser=SOF, m_tlast=EOF) with frame_err on DMA framing mismatch
module axis_rgb_unpacker
  import axis_rgb_unpacker_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        frame_err
);
  localparam int PIX_N = H_ACTIVE * V_ACTIVE;
  localparam int WRD_N = PIX_N / 4 * 3;
  localparam int PW = $clog2(PIX_N);
  localparam int WW = $clog2(WRD_N);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_N - 1);
  localparam logic [WW-1:0] WRD_LAST = WW'(WRD_N - 1);
  phase_t phase;
  logic [23:0] lo;
  logic [23:0] lo_nxt;
  logic [PW-1:0] pix_cnt;
  logic [WW-1:0] wrd_cnt;
  logic [31:0] pix;
  logic adv, acc, emit, word_last, early, miss, px_last, px_user;
  assign s_tready = rst_n & (phase != P3) & adv;
  assign acc = s_tvalid & s_tready;
  assign emit = acc | (adv & (phase == P3));
  assign word_last = wrd_cnt == WRD_LAST;
  assign early = s_tlast & !word_last;
  assign miss = !s_tlast & word_last;
  assign px_last = (pix_cnt == PIX_LAST) | (acc & early);
  assign px_user = pix_cnt == '0;
  always_comb begin
    pix = phase == P0 ? pack_px(s_tdata[7:0], s_tdata[15:8], s_tdata[23:16]) :
          phase == P1 ? pack_px(lo[7:0], s_tdata[7:0], s_tdata[15:8]) :
          phase == P2 ? pack_px(lo[7:0], lo[15:8], s_tdata[7:0]) :
                        pack_px(lo[7:0], lo[15:8], lo[23:16]);
    lo_nxt = phase == P0 ? {16'h0, s_tdata[31:24]} :
             phase == P1 ? {8'h0, s_tdata[31:16]} :
                           s_tdata[31:8];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= P0;
      lo        <= '0;
      pix_cnt   <= '0;
      wrd_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= acc & (early | miss);
      if (acc & early) begin
        phase   <= P0;
        lo      <= '0;
        pix_cnt <= '0;
        wrd_cnt <= '0;
      end else if (emit) begin
        phase   <= phase_t'(phase + 2'd1);
        pix_cnt <= pix_cnt == PIX_LAST ? '0 : pix_cnt + 1'b1;
        if (acc) begin
          wrd_cnt <= word_last ? '0 : wrd_cnt + 1'b1;
          lo      <= lo_nxt;
        end
      end
    end
  end
  axis_reg_slice #(.DATA_W(34)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  ({px_user, px_last, pix}),
    .s_valid (emit),
    .s_ready (adv),
    .m_data  ({m_tuser, m_tlast, m_tdata}),
    .m_valid (m_tvalid),
    .m_ready (m_tready)
  );
endmodule
